fsize_fifo_writer: RTL and testbench
====================================

Name: fsize_fifo_writer

Overview:
- Write-side producer/flow-control front end for the team's non-power-of-two dual-clock FIFO (two memories, depth LEN_SUM = 2^LEN_LOG_A + 2^LEN_LOG_B, no flags).
- Accepts a valid/ready stream in the WCLK domain and drives the FIFO's enq/din.
- Tracks occupancy against a read-pointer snapshot that the RCLK-side reader hands over through a toggle req/ack handshake.
- Never issues enq into a full FIFO.

Parameters:
- DW, 32, data width.
- LEN_LOG_A, 12, log2 of the larger FIFO memory; must be greater than LEN_LOG_B.
- LEN_LOG_B, 9, log2 of the smaller FIFO memory.
- LEN_SUM, (1<<LEN_LOG_A)+(1<<LEN_LOG_B), FIFO depth in entries.
- PW, LEN_LOG_A+2, pointer width; covers the range 0..2*LEN_SUM-1.
- AFULL_TH, LEN_SUM-16, almost_full threshold in entries.

Ports:
- WCLK  in  1  write clock; all logic on posedge.
- RST_X  in  1  reset, asynchronous, active-low.
- WRST  in  1  synchronous write-domain reset, active-high.
- s_valid  in  1  upstream data valid.
- s_data  in  DW  upstream data.
- s_ready  out  1  upstream may transfer this cycle.
- enq  out  1  FIFO write enable (registered).
- din  out  DW  FIFO write data (registered).
- rptr_snap  in  PW  reader's extended read pointer (0..2*LEN_SUM-1); held stable by RCLK side while a request is outstanding.
- rsnap_req  in  1  request toggle from RCLK domain; asynchronous to WCLK.
- wsnap_ack  out  1  acknowledge toggle back to RCLK domain.
- wcount  out  PW  current occupancy seen from the write side.
- almost_full  out  1  wcount >= AFULL_TH.
- ptr_err  out  1  sticky: invalid snapshot detected.

Behaviour:
- Reset (RST_X low, async) and WRST (sync) both clear:
  - wptr=0, rptr_w=0, enq=0, din=0, ptr_err=0.
  - Resulting outputs: wcount=0, almost_full=0 (for AFULL_TH>0), s_ready=1.
- RST_X low additionally clears the synchronizer req_s1/req_s2/req_s3 and wsnap_ack=0. WRST leaves these untouched; RCLK side must apply RRST concurrently.
- Accept: acc = s_valid & s_ready.
  - s_ready = (wcount < LEN_SUM) & ~ptr_err; depends only on registers, never on s_valid.
- On acc:
  - Next cycle: enq=1, din=s_data (latency 1 WCLK); otherwise enq=0 and din holds.
  - wptr increments; wptr==2*LEN_SUM-1 wraps to 0.
  - FIFO internal address equals wptr mod LEN_SUM.
- Occupancy: wcount = wptr - rptr_w if wptr >= rptr_w, else wptr + 2*LEN_SUM - rptr_w.
  - Full when wcount == LEN_SUM; s_ready drops in the cycle after the LEN_SUM-th outstanding accept.
- Snapshot handshake:
  - rsnap_req passes through a 2-FF synchronizer (req_s1, req_s2); req_s3 <= req_s2.
  - When req_s2 != req_s3: rptr_w <= rptr_snap and wsnap_ack <= req_s2.
  - Capture occurs on the 3rd WCLK edge after the toggle reaches req_s1 input; wcount and s_ready update the following cycle.
  - Reader must not toggle again until it sees the ack.
- Stale rptr_w is conservative (under-reports free space); correctness requires no other rule.
- Accept and capture in the same cycle: both take effect; wcount is computed from the new wptr and new rptr_w.
- ptr_err:
  - Set if the computed wcount > LEN_SUM, or if a captured rptr_snap >= 2*LEN_SUM.
  - Sticky until RST_X or WRST.
  - While set, s_ready=0 and rptr_w captures continue.
- almost_full is combinational from wcount.

Test Plan (LEN_LOG_A=3, LEN_LOG_B=1 -> LEN_SUM=10, PW=5, AFULL_TH=8):
1. Reset: assert RST_X low mid-stream with s_valid=1 -> s_ready=1, enq=0, din=0, wcount=0, wsnap_ack=0, ptr_err=0 immediately; no enq for 1 cycle after release.
2. Fill: s_valid=1 continuously, data 0..11, no snapshot.
   - Exactly 10 accepts; enq pulses carry 0..9 one cycle after each accept.
   - almost_full rises with wcount=8; s_ready=0 from wcount=10; data 10 held until space frees.
3. Drain update: from full, toggle rsnap_req with rptr_snap=4 -> wsnap_ack toggles and wcount=6 after 3-4 WCLK; s_ready=1; stalled beat 10 accepted.
4. Wrap: stream 25 beats with snapshots tracking the reader -> wptr goes 19->0; wcount never exceeds 10; enq order is 0..24; ptr_err stays 0.
5. Collision:
   - Accept in the same cycle as capture of rptr_snap=wptr-2 -> wcount=3 next cycle.
   - Then capture rptr_snap=25 -> ptr_err=1 and s_ready=0.
   - Then WRST -> ptr_err=0 and wcount=0.
6. WRST mid-stream with pending enq -> enq=0 next cycle; wptr=0; synchronizer state and wsnap_ack level unchanged.

Source files
------------

// File: rtl/fsize_fifo_writer_if.sv
// Upstream valid/ready stream feeding the FIFO write front end.
// The master drives valid/data; the slave (writer) returns ready.
interface fsize_fifo_writer_if #(
   parameter int DW = 32
) ();
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/fsize_fifo_writer.sv
// Write-side front end for the non-power-of-two dual-clock FIFO.
// Turns an upstream valid/ready stream into registered enq/din and
// tracks occupancy against a read-pointer snapshot that the RCLK side
// hands over with a toggle req/ack handshake. Pointers run over
// 0..2*LEN_SUM-1 so that full and empty stay distinguishable.
module fsize_fifo_writer #(
   parameter int DW        = 32,
   parameter int LEN_LOG_A = 12,
   parameter int LEN_LOG_B = 9,
   parameter int LEN_SUM   = (1 << LEN_LOG_A) + (1 << LEN_LOG_B),
   parameter int PW        = LEN_LOG_A + 2,
   parameter int AFULL_TH  = LEN_SUM - 16
) (
   input  logic                WCLK,
   input  logic                RST_X,
   input  logic                WRST,
   fsize_fifo_writer_if.slave  s_if,
   output logic                enq,
   output logic [DW-1:0]       din,
   input  logic [PW-1:0]       rptr_snap,
   input  logic                rsnap_req,
   output logic                wsnap_ack,
   output logic [PW-1:0]       wcount,
   output logic                almost_full,
   output logic                ptr_err
);

   localparam logic [PW-1:0] DEPTH    = PW'(LEN_SUM);
   localparam logic [PW-1:0] PTR_MAX  = PW'(2 * LEN_SUM - 1);
   localparam logic [PW-1:0] PTR_SPAN = PW'(2 * LEN_SUM);
   localparam logic [PW-1:0] AFULL    = PW'(AFULL_TH);

   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr_w;
   logic          req_s1;
   logic          req_s2;
   logic          req_s3;
   logic          capture;
   logic          ready_int;
   logic          acc;

   // Occupancy from the extended pointers; the wrapped case adds the
   // span back (PW bits are wide enough for 2*LEN_SUM-1).
   always_comb begin
      wcount = '0;
      if (wptr >= rptr_w) begin
         wcount = wptr - rptr_w;
      end else begin
         wcount = wptr + PTR_SPAN - rptr_w;
      end
   end

   assign almost_full = (wcount >= AFULL);
   // Ready depends only on registered state so it never combinationally
   // follows s_valid.
   assign ready_int   = (wcount < DEPTH) & ~ptr_err;
   assign s_if.s_ready = ready_int;
   assign acc         = s_if.s_valid & ready_int;
   assign capture     = req_s2 ^ req_s3;

   // Request toggle synchronizer and acknowledge; only the async reset
   // clears these so a write-domain soft reset cannot lose a handshake.
   always_ff @(posedge WCLK or negedge RST_X) begin
      if (!RST_X) begin
         req_s1    <= 1'b0;
         req_s2    <= 1'b0;
         req_s3    <= 1'b0;
         wsnap_ack <= 1'b0;
      end else begin
         req_s1 <= rsnap_req;
         req_s2 <= req_s1;
         req_s3 <= req_s2;
         if (capture) begin
            wsnap_ack <= req_s2;
         end
      end
   end

   // Write pointer, read-pointer snapshot, registered FIFO write port and
   // sticky pointer error. rptr_snap is stable while a request is
   // outstanding, so sampling it on the capture edge is safe.
   always_ff @(posedge WCLK or negedge RST_X) begin
      if (!RST_X) begin
         wptr    <= '0;
         rptr_w  <= '0;
         enq     <= 1'b0;
         din     <= '0;
         ptr_err <= 1'b0;
      end else if (WRST) begin
         wptr    <= '0;
         rptr_w  <= '0;
         enq     <= 1'b0;
         din     <= '0;
         ptr_err <= 1'b0;
      end else begin
         enq <= acc;
         if (acc) begin
            din  <= s_if.s_data;
            wptr <= (wptr == PTR_MAX) ? '0 : wptr + 1'b1;
         end
         if (capture) begin
            rptr_w <= rptr_snap;
         end
         if ((wcount > DEPTH) || (capture && (rptr_snap > PTR_MAX))) begin
            ptr_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fsize_fifo_writer.sv
// Bench for fsize_fifo_writer with a small FIFO (LEN_SUM=10).
// The reference model counts accepted beats and reader progress as plain
// integers; occupancy is their difference, and the snapshot handshake is
// modelled as a fixed three-edge delay from the request toggle.
module tb_fsize_fifo_writer;
   localparam int DW = 16;
   localparam int LA = 3;
   localparam int LB = 1;
   localparam int LS = 10;
   localparam int PW = 5;
   localparam int TH = 8;

   logic          WCLK = 1'b0;
   logic          RST_X = 1'b0;
   logic          WRST = 1'b0;
   logic          enq;
   logic [DW-1:0] din;
   logic [PW-1:0] rptr_snap = '0;
   logic          rsnap_req = 1'b0;
   logic          wsnap_ack;
   logic [PW-1:0] wcount;
   logic          almost_full;
   logic          ptr_err;

   fsize_fifo_writer_if #(.DW(DW)) s_if ();

   fsize_fifo_writer #(
      .DW(DW), .LEN_LOG_A(LA), .LEN_LOG_B(LB), .LEN_SUM(LS), .PW(PW), .AFULL_TH(TH)
   ) dut (
      .WCLK(WCLK), .RST_X(RST_X), .WRST(WRST), .s_if(s_if),
      .enq(enq), .din(din), .rptr_snap(rptr_snap), .rsnap_req(rsnap_req),
      .wsnap_ack(wsnap_ack), .wcount(wcount), .almost_full(almost_full),
      .ptr_err(ptr_err)
   );

   always #5 WCLK = ~WCLK;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   int            wr_total;
   int            rd_cap;
   int            rd_total;
   int            cap_cnt;
   int            pend_total;
   bit            pend_bad;
   bit            m_err;
   bit            m_enq;
   bit            exp_ack;
   logic [DW-1:0] m_din;
   int            seq;
   int            n_enq;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_wcount();
      return wr_total - rd_cap;
   endfunction

   function automatic bit m_ready();
      return (m_wcount() < LS) && !m_err;
   endfunction

   task automatic model_reset(input bit full);
      wr_total = 0;
      rd_cap   = 0;
      m_err    = 1'b0;
      m_enq    = 1'b0;
      m_din    = '0;
      if (full) begin
         exp_ack = 1'b0;
         cap_cnt = 0;
      end
   endtask

   task automatic send_snap(input int total, input bit bad);
      rptr_snap  = bad ? PW'(25) : PW'(total % (2 * LS));
      pend_total = total;
      pend_bad   = bad;
      rsnap_req  = ~rsnap_req;
      cap_cnt    = 3;
   endtask

   // One WCLK cycle: check outputs at the falling edge, then advance the
   // model over the rising edge. Inputs are changed by callers at posedge+1.
   task automatic cycle();
      bit            acc;
      bit            cap_now;
      logic [DW-1:0] d;
      @(negedge WCLK);
      if (!m_err) begin
         chk("wcount", 32'(wcount), 32'(m_wcount()));
         chk("almost_full", 32'(almost_full), 32'(m_wcount() >= TH));
      end
      chk("s_ready", 32'(s_if.s_ready), 32'(m_ready()));
      chk("enq", 32'(enq), 32'(m_enq));
      chk("din", 32'(din), 32'(m_din));
      chk("ptr_err", 32'(ptr_err), 32'(m_err));
      chk("wsnap_ack", 32'(wsnap_ack), 32'(exp_ack));
      if (enq) n_enq++;
      acc = s_if.s_valid && m_ready() && RST_X && !WRST;
      d   = s_if.s_data;
      @(posedge WCLK);
      if (!RST_X) begin
         model_reset(1'b1);
      end else begin
         cap_now = 1'b0;
         if (cap_cnt > 0) begin
            cap_cnt--;
            if (cap_cnt == 0) cap_now = 1'b1;
         end
         if (cap_now) exp_ack = rsnap_req;
         if (WRST) begin
            model_reset(1'b0);
         end else begin
            m_enq = acc;
            if (acc) begin
               m_din = d;
               wr_total++;
            end
            if (cap_now) begin
               if (pend_bad) m_err = 1'b1;
               else rd_cap = pend_total;
            end
         end
      end
      #1;
      if (acc) seq++;
      s_if.s_data = DW'(seq);
   endtask

   initial begin
      int avail;
      bit saved_ack;
      s_if.s_valid = 1'b0;
      s_if.s_data  = '0;
      seq = 0; n_enq = 0; rd_total = 0; pend_total = 0; pend_bad = 1'b0;
      model_reset(1'b1);
      repeat (2) @(posedge WCLK);
      #1 RST_X = 1'b1;
      repeat (2) cycle();

      // 1: async reset in the middle of a stream
      s_if.s_valid = 1'b1;
      repeat (3) cycle();
      #2 RST_X = 1'b0;
      #1;
      chk("rst_s_ready", 32'(s_if.s_ready), 32'd1);
      chk("rst_enq", 32'(enq), 32'd0);
      chk("rst_din", 32'(din), 32'd0);
      chk("rst_wcount", 32'(wcount), 32'd0);
      chk("rst_ack", 32'(wsnap_ack), 32'd0);
      chk("rst_ptr_err", 32'(ptr_err), 32'd0);
      model_reset(1'b1);
      rsnap_req = 1'b0;
      rd_total  = 0;
      seq = 0;
      s_if.s_data = '0;
      cycle();
      RST_X = 1'b1;

      // 2: fill until full, beat 10 stalls
      n_enq = 0;
      repeat (20) cycle();
      chk("fill_enq_count", 32'(n_enq), 32'd10);
      chk("fill_wcount", 32'(wcount), 32'd10);
      chk("fill_ready", 32'(s_if.s_ready), 32'd0);
      chk("fill_held", 32'(s_if.s_data), 32'd10);

      // 3: reader reports 4 entries consumed
      rd_total = 4;
      send_snap(rd_total, 1'b0);
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (wsnap_ack == rsnap_req) break;
      end
      chk("drain_ack", 32'(wsnap_ack), 32'(rsnap_req));
      chk("drain_wcount", 32'(wcount), 32'd6);
      chk("drain_ready", 32'(s_if.s_ready), 32'd1);
      cycle();
      chk("beat10_enq", 32'(enq), 32'd1);
      chk("beat10_din", 32'(din), 32'd10);

      // 4: random stream with a tracking reader, pointers wrap
      for (int i = 0; i < 400; i++) begin
         s_if.s_valid = ($urandom_range(0, 3) != 0);
         if (rsnap_req == exp_ack && cap_cnt == 0 && $urandom_range(0, 2) == 0) begin
            avail = wr_total - (m_enq ? 1 : 0) - rd_total;
            if (avail > 0) rd_total += $urandom_range(0, avail);
            send_snap(rd_total, 1'b0);
         end
         cycle();
      end
      s_if.s_valid = 1'b0;
      repeat (4) cycle();

      // 5: full drain, then accept coinciding with capture, then bad pointer
      rd_total = wr_total;
      send_snap(rd_total, 1'b0);
      repeat (4) cycle();
      chk("drain_all_wcount", 32'(wcount), 32'd0);
      s_if.s_valid = 1'b1;
      rd_total = wr_total;
      send_snap(rd_total, 1'b0);
      repeat (3) cycle();
      s_if.s_valid = 1'b0;
      chk("collide_wcount", 32'(wcount), 32'd3);
      cycle();
      s_if.s_valid = 1'b1;
      send_snap(0, 1'b1);
      repeat (4) cycle();
      chk("bad_ptr_err", 32'(ptr_err), 32'd1);
      chk("bad_ready", 32'(s_if.s_ready), 32'd0);
      WRST = 1'b1;
      cycle();
      WRST = 1'b0;
      rd_total = 0;
      chk("wrst_clr_err", 32'(ptr_err), 32'd0);
      chk("wrst_clr_wcount", 32'(wcount), 32'd0);
      repeat (3) cycle();

      // 6: soft reset with an enq pending
      s_if.s_valid = 1'b1;
      cycle();
      chk("pend_enq", 32'(enq), 32'd1);
      saved_ack = wsnap_ack;
      WRST = 1'b1;
      cycle();
      WRST = 1'b0;
      s_if.s_valid = 1'b0;
      rd_total = 0;
      chk("wrst_enq", 32'(enq), 32'd0);
      chk("wrst_wcount", 32'(wcount), 32'd0);
      chk("wrst_ack_hold", 32'(wsnap_ack), 32'(saved_ack));
      send_snap(0, 1'b0);
      repeat (5) cycle();
      chk("post_wrst_ack", 32'(wsnap_ack), 32'(rsnap_req));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
